// File: rtl/max_pool_scheduler.sv
// 2x2 / stride-2 signed max-pool sequencer over a feature map in external RAM.
// Four tap reads per output window, running maximum, valid/ready result stream.
// Optional build macro POOL_ARGMAX_EN: out_idx reports the winning tap (0-3).
module max_pool_scheduler #(
  parameter int unsigned H       = 256,
  parameter int unsigned W       = 256,
  parameter int unsigned FILTERS = 64,
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_idx
);

  localparam int unsigned KW = (FILTERS > 1) ? $clog2(FILTERS) : 1;
  localparam int unsigned IW = (H / 2 > 1) ? $clog2(H / 2) : 1;
  localparam int unsigned JW = (W / 2 > 1) ? $clog2(W / 2) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_WAIT, ST_OUT, ST_FIN} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [1:0]    tap_q, tap_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          out_valid_q, out_valid_d;
  logic          rd_vld_q;
  logic [1:0]    rd_tap_q;
  logic [DW-1:0] out_data_q;
  logic          last_win;

  // Address of tap t of window (k,i,j): row 2i+t[1], column 2j+t[0].
  function automatic logic [AW-1:0] tap_addr(input logic [KW-1:0] k, input logic [IW-1:0] i,
                                             input logic [JW-1:0] j, input logic [1:0] t);
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    row = AW'({i, t[1]});
    col = AW'({j, t[0]});
    return (AW'(k) * AW'(H) + row) * AW'(W) + col;
  endfunction

  assign last_win = (k_q == KW'(FILTERS - 1)) && (i_q == IW'(H / 2 - 1)) && (j_q == JW'(W / 2 - 1));

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    i_d         = i_q;
    j_d         = j_q;
    tap_d       = tap_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_READ;
          k_d       = '0;
          i_d       = '0;
          j_d       = '0;
          tap_d     = '0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = tap_addr('0, '0, '0, 2'd0);
        end
      end
      ST_READ: begin
        if (tap_q == 2'd3) begin
          state_d = ST_WAIT;
        end else begin
          tap_d     = tap_q + 2'd1;
          rd_en_d   = 1'b1;
          rd_addr_d = tap_addr(k_q, i_q, j_q, tap_q + 2'd1);
        end
      end
      ST_WAIT: begin
        state_d     = ST_OUT;
        out_valid_d = 1'b1;
      end
      ST_OUT: begin
        out_valid_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          tap_d       = '0;
          if (last_win) begin
            state_d = ST_FIN;
            k_d     = '0;
            i_d     = '0;
            j_d     = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            if (j_q == JW'(W / 2 - 1)) begin
              j_d = '0;
              if (i_q == IW'(H / 2 - 1)) begin
                i_d = '0;
                k_d = k_q + KW'(1);
              end else begin
                i_d = i_q + IW'(1);
              end
            end else begin
              j_d = j_q + JW'(1);
            end
            state_d   = ST_READ;
            rd_en_d   = 1'b1;
            rd_addr_d = tap_addr(k_d, i_d, j_d, 2'd0);
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      tap_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      i_q         <= i_d;
      j_q         <= j_d;
      tap_q       <= tap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Track which tap the returning read data belongs to (RAM latency is one cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_tap_q <= '0;
    end else begin
      rd_vld_q <= rd_en_q;
      if (rd_en_q) rd_tap_q <= tap_q;
    end
  end

  // Running maximum: tap 0 loads, later taps replace only when strictly greater.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
    end else if (rd_vld_q && ((rd_tap_q == 2'd0) || ($signed(rd_data) > $signed(out_data_q)))) begin
      out_data_q <= rd_data;
    end
  end

`ifdef POOL_ARGMAX_EN
  logic [1:0] idx_q;

  // Winning tap index, updated together with the running maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (rd_vld_q && ((rd_tap_q == 2'd0) || ($signed(rd_data) > $signed(out_data_q)))) begin
      idx_q <= rd_tap_q;
    end
  end

  assign out_idx = idx_q;
`else
  assign out_idx = 2'b00;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
